// File: rtl/rmux_bus_capture.sv
// rmux_bus_capture: receive-side capture for the inverted, phase-multiplexed
// RMUX address/data bus. Pairs each address phase with the following data
// phase, buffers completed transactions in a 2-entry FIFO and flags and
// counts protocol errors.
module rmux_bus_capture #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             sysclk,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] bus_n,
    input  logic             ra_i,
    input  logic             rd_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0] data_o,
    output logic             err_o,
    output logic [7:0]       err_cnt
);

    typedef enum logic [0:0] {StIdle, StAddr} capState_e;

    capState_e        stateQ, stateD;
    logic [WIDTH-1:0] busTrue;
    logic             raOnly, rdOnly, bothStrobe;
    logic             loadAddr, pushReq, push, pop, fifoFull, errDet;
    logic [WIDTH-1:0] addrHold;
    logic [WIDTH-1:0] addrMem [2];
    logic [WIDTH-1:0] dataMem [2];
    logic             wrPtr, rdPtr;
    logic [1:0]       count;

    // Bus is driven active-low by the AND-NOR stages.
    assign busTrue    = ~bus_n;
    assign raOnly     = ra_i & ~rd_i;
    assign rdOnly     = rd_i & ~ra_i;
    assign bothStrobe = ra_i & rd_i;
    assign fifoFull   = (count == 2'd2);

    // Capture FSM state register.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Capture FSM next-state; contention always returns to idle.
    always_comb begin
        stateD = stateQ;
        if (bothStrobe) begin
            stateD = StIdle;
        end else begin
            case (stateQ)
                StIdle:  if (raOnly) stateD = StAddr;
                StAddr:  if (rdOnly) stateD = StIdle;
                default: stateD = StIdle;
            endcase
        end
    end

    // Capture FSM outputs: address load, FIFO push and error detection.
    always_comb begin
        loadAddr = raOnly;
        pushReq  = (stateQ == StAddr) && rdOnly;
        pop      = out_valid & out_ready;
        // A same-cycle pop frees a slot for the incoming word.
        push     = pushReq & (~fifoFull | pop);
        errDet   = bothStrobe | ((stateQ == StIdle) && rdOnly) | (pushReq & ~push);
    end

    // Held address; re-addressing simply overwrites it.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            addrHold <= '0;
        end else if (loadAddr) begin
            addrHold <= busTrue;
        end
    end

    // Two-entry transaction FIFO.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                addrMem[i] <= '0;
                dataMem[i] <= '0;
            end
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                addrMem[wrPtr] <= addrHold;
                dataMem[wrPtr] <= busTrue;
                wrPtr          <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Error pulse and saturating error counter.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_o   <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            err_o <= errDet;
            if (errDet && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    // Head presentation; forced to zero when empty so stale slots never leak.
    always_comb begin
        out_valid = (count != 2'd0);
        addr_o    = out_valid ? addrMem[rdPtr] : '0;
        data_o    = out_valid ? dataMem[rdPtr] : '0;
    end

endmodule

// File: tb/tb_rmux_bus_capture.sv
// Directed bench for rmux_bus_capture: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences.
module tb_rmux_bus_capture;

    logic        sysclk;
    logic        sys_rst_n;
    logic [15:0] bus_n;
    logic        ra_i;
    logic        rd_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] addr_o;
    logic [15:0] data_o;
    logic        err_o;
    logic [7:0]  err_cnt;

    int nCmp;
    int nErr;

    typedef struct {
        logic        ra;
        logic        rd;
        logic        rdy;
        logic [15:0] val;
        logic        eValid;
        logic [15:0] eAddr;
        logic [15:0] eData;
        logic        eErr;
        logic [7:0]  eCnt;
    } vec_t;

    vec_t vq[$];

    rmux_bus_capture #(.WIDTH(16)) dut (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .bus_n     (bus_n),
        .ra_i      (ra_i),
        .rd_i      (rd_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .addr_o    (addr_o),
        .data_o    (data_o),
        .err_o     (err_o),
        .err_cnt   (err_cnt)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus (true-polarity value), then sample after the edge.
    task automatic cyc(input logic ra, input logic rd, input logic [15:0] val, input logic rdy);
        ra_i      = ra;
        rd_i      = rd;
        bus_n     = ~val;
        out_ready = rdy;
        @(posedge sysclk);
        #1;
        ra_i = 1'b0;
        rd_i = 1'b0;
    endtask

    task automatic add(input logic ra, input logic rd, input logic rdy, input logic [15:0] val,
                       input logic ev, input logic [15:0] ea, input logic [15:0] ed,
                       input logic ee, input logic [7:0] ec);
        vec_t v;
        v.ra = ra; v.rd = rd; v.rdy = rdy; v.val = val;
        v.eValid = ev; v.eAddr = ea; v.eData = ed; v.eErr = ee; v.eCnt = ec;
        vq.push_back(v);
    endtask

    task automatic chkOut(input string tag, input logic ev, input logic [15:0] ea,
                          input logic [15:0] ed, input logic ee, input logic [7:0] ec);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, ".addr"},  {16'd0, addr_o},    {16'd0, ea});
        chk({tag, ".data"},  {16'd0, data_o},    {16'd0, ed});
        chk({tag, ".err"},   {31'd0, err_o},     {31'd0, ee});
        chk({tag, ".cnt"},   {24'd0, err_cnt},   {24'd0, ec});
    endtask

    task automatic doReset();
        sys_rst_n = 1'b0;
        #3;
        @(posedge sysclk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        nCmp      = 0;
        nErr      = 0;
        sys_rst_n = 1'b0;
        ra_i      = 1'b0;
        rd_i      = 1'b0;
        bus_n     = 16'hFFFF;
        out_ready = 1'b0;

        //   ra rd rdy val       valid addr     data     err cnt
        add(1, 0, 1, 16'h1234, 0, 16'h0000, 16'h0000, 0, 8'd0);
        add(0, 1, 1, 16'hABCD, 1, 16'h1234, 16'hABCD, 0, 8'd0);
        add(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 8'd0);
        add(0, 1, 1, 16'h9999, 0, 16'h0000, 16'h0000, 1, 8'd1); // orphan data
        add(1, 1, 1, 16'h8888, 0, 16'h0000, 16'h0000, 1, 8'd2); // contention
        add(1, 0, 1, 16'h1111, 0, 16'h0000, 16'h0000, 0, 8'd2);
        add(1, 0, 0, 16'h0055, 0, 16'h0000, 16'h0000, 0, 8'd2); // re-address
        add(0, 1, 0, 16'h7777, 1, 16'h0055, 16'h7777, 0, 8'd2);
        add(0, 0, 0, 16'h0000, 1, 16'h0055, 16'h7777, 0, 8'd2); // held under stall
        add(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 8'd2);
        add(1, 0, 1, 16'h2222, 0, 16'h0000, 16'h0000, 0, 8'd2);
        add(1, 1, 1, 16'h4444, 0, 16'h0000, 16'h0000, 1, 8'd3); // contention in ADDR
        add(0, 1, 1, 16'h3333, 0, 16'h0000, 16'h0000, 1, 8'd4); // now orphan
        add(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 8'd4);
        add(1, 0, 1, 16'h0A0A, 0, 16'h0000, 16'h0000, 0, 8'd4); // back-to-back
        add(0, 1, 1, 16'h0B0B, 1, 16'h0A0A, 16'h0B0B, 0, 8'd4);
        add(1, 0, 1, 16'h0C0C, 0, 16'h0000, 16'h0000, 0, 8'd4);
        add(0, 1, 1, 16'h0D0D, 1, 16'h0C0C, 16'h0D0D, 0, 8'd4);
        add(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 8'd4);

        // Reset state
        repeat (2) @(posedge sysclk);
        #1;
        chkOut("reset", 1'b0, 16'h0000, 16'h0000, 1'b0, 8'd0);
        sys_rst_n = 1'b1;

        foreach (vq[i]) begin
            cyc(vq[i].ra, vq[i].rd, vq[i].val, vq[i].rdy);
            chkOut($sformatf("vec%0d", i), vq[i].eValid, vq[i].eAddr, vq[i].eData,
                   vq[i].eErr, vq[i].eCnt);
        end

        // Backpressure: third transaction dropped with an error
        doReset();
        cyc(1'b1, 1'b0, 16'h1001, 1'b0);
        cyc(1'b0, 1'b1, 16'hD001, 1'b0);
        cyc(1'b1, 1'b0, 16'h1002, 1'b0);
        cyc(1'b0, 1'b1, 16'hD002, 1'b0);
        chkOut("bp.full", 1'b1, 16'h1001, 16'hD001, 1'b0, 8'd0);
        cyc(1'b1, 1'b0, 16'h1003, 1'b0);
        cyc(1'b0, 1'b1, 16'hD003, 1'b0);
        chkOut("bp.drop", 1'b1, 16'h1001, 16'hD001, 1'b1, 8'd1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chkOut("bp.pop1", 1'b1, 16'h1002, 16'hD002, 1'b0, 8'd1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chkOut("bp.pop2", 1'b0, 16'h0000, 16'h0000, 1'b0, 8'd1);

        // Full FIFO with simultaneous pop on the push edge
        cyc(1'b1, 1'b0, 16'h3001, 1'b0);
        cyc(1'b0, 1'b1, 16'hE001, 1'b0);
        cyc(1'b1, 1'b0, 16'h3002, 1'b0);
        cyc(1'b0, 1'b1, 16'hE002, 1'b0);
        cyc(1'b1, 1'b0, 16'h3003, 1'b0);
        cyc(1'b0, 1'b1, 16'hE003, 1'b1);
        chkOut("fp.push", 1'b1, 16'h3002, 16'hE002, 1'b0, 8'd1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chkOut("fp.pop2", 1'b1, 16'h3003, 16'hE003, 1'b0, 8'd1);
        cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        chkOut("fp.empty", 1'b0, 16'h0000, 16'h0000, 1'b0, 8'd1);

        // Saturation: each orphan pulse still raises err_o
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 1'b1, 16'h5A5A, 1'b1);
            chk($sformatf("sat.err%0d", i), {31'd0, err_o}, 32'd1);
            cyc(1'b0, 1'b0, 16'h0000, 1'b1);
        end
        chkOut("sat.end", 1'b0, 16'h0000, 16'h0000, 1'b0, 8'd255);

        // Asynchronous reset in ADDR with one buffered entry
        cyc(1'b1, 1'b0, 16'h4001, 1'b0);
        cyc(1'b0, 1'b1, 16'hF001, 1'b0);
        cyc(1'b1, 1'b0, 16'h4002, 1'b0);
        chkOut("rst.pre", 1'b1, 16'h4001, 16'hF001, 1'b0, 8'd255);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chkOut("rst.async", 1'b0, 16'h0000, 16'h0000, 1'b0, 8'd0);
        @(posedge sysclk);
        #1;
        sys_rst_n = 1'b1;
        chkOut("rst.hold", 1'b0, 16'h0000, 16'h0000, 1'b0, 8'd0);
        cyc(1'b0, 1'b1, 16'h5555, 1'b1);
        chkOut("rst.orphan", 1'b0, 16'h0000, 16'h0000, 1'b1, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/rmux_bus_capture.md
# rmux_bus_capture

Receive-side capture for the inverted, phase-multiplexed address/data bus driven by the RMUX AND-NOR gate stages. The block samples the active-low bus during address and data strobe phases, restores true polarity, and pairs each address with its following data word. Completed transactions are buffered in a 2-entry FIFO and presented on a valid/ready port to the CPU-side consumer. Protocol violations are flagged and counted.

## Interface
- WIDTH, 16, bus and address/data width
- sysclk  in  1  system clock, rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- bus_n  in  WIDTH  multiplexed bus, active-low (bit = ~(A&RA | D&RD))
- ra_i  in  1  address-phase strobe, synchronous to sysclk
- rd_i  in  1  data-phase strobe, synchronous to sysclk
- out_valid  out  1  FIFO head holds a transaction
- out_ready  in  1  consumer accepts head when high with out_valid
- addr_o  out  WIDTH  address of head transaction
- data_o  out  WIDTH  data of head transaction
- err_o  out  1  one-cycle pulse on any protocol error
- err_cnt  out  8  saturating protocol-error count

## Operation
- Capture FSM states: IDLE, ADDR (address held, awaiting data).
- IDLE, ra_i=1, rd_i=0: addr_hold <= ~bus_n; go ADDR.
- ADDR, rd_i=1, ra_i=0: push {addr_hold, ~bus_n} into FIFO; go IDLE. If FIFO full at that edge (after counting a same-cycle pop): drop the word, err_o, go IDLE.
- ADDR, ra_i=1, rd_i=0: re-address; addr_hold overwritten with ~bus_n, stay ADDR, no error.
- IDLE, rd_i=1, ra_i=0: orphan data; discarded, err_o.
- ra_i=1 and rd_i=1 same cycle (bus contention, wired-OR content): discarded in any state, err_o, FSM to IDLE, addr_hold unchanged.
- Neither strobe: state held.
- FIFO: 2 entries, pointers wrap mod 2, occupancy count 0..2. Pop when out_valid & out_ready. Push and pop in the same cycle at count 2 is legal: pop frees the slot, push succeeds, count stays 2. Push and pop at count 1: count stays 1, head advances.
- out_valid = (count != 0); addr_o/data_o show head entry; undefined content not permitted: outputs 0 when empty.
- err_cnt increments on each err_o pulse, saturates at 255, cleared only by reset.

## Timing
- All state updates on rising sysclk; strobes and bus_n sampled at the same edge.
- Latency: rd_i edge completing a transaction -> out_valid high after that same edge (1-cycle registered latency), data stable on addr_o/data_o.
- Back-to-back transactions: ra, rd, ra, rd on four consecutive cycles sustain one transaction per 2 cycles.
- out_valid/addr_o/data_o hold stable while out_valid & !out_ready.
- err_o high for exactly the cycle following the offending edge.
- Reset (any time, including ADDR state or FIFO non-empty): state IDLE, addr_hold 0, count 0, pointers 0, out_valid 0, addr_o 0, data_o 0, err_o 0, err_cnt 0. Pending and buffered transactions lost; no output glitch after deassertion.
- First strobe sampled at the first rising edge with sys_rst_n high.

## Test plan
- Single transaction: bus_n=~16'h1234 with ra_i, next cycle bus_n=~16'hABCD with rd_i, out_ready=1 -> out_valid for one cycle with addr_o=16'h1234, data_o=16'hABCD, err_o never set.
- Backpressure: out_ready=0, three complete transactions (A1/D1, A2/D2, A3/D3) -> FIFO holds first two, third dropped with err_o pulse, err_cnt=1; then out_ready=1 yields A1/D1 then A2/D2, out_valid falls.
- Full with simultaneous pop: FIFO full, out_ready=1 in the rd_i cycle of a third transaction -> no error, count stays 2, transactions delivered in order.
- Protocol errors: rd_i in IDLE, then ra_i&rd_i together, then ra_i, ra_i (re-address 16'h0055), rd_i -> err_cnt=2, one transaction with addr_o=16'h0055.
- Saturation: 300 orphan rd_i pulses -> err_cnt=255, err_o still pulses each time.
- Reset mid-operation: assert sys_rst_n=0 in ADDR state with one FIFO entry -> all outputs 0 asynchronously; after release, rd_i alone produces err_o, not a transaction.
